// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared FSM states, beat/channel geometry and beat-to-channel slicing for mac_stream_feeder
package mac_feeder_pkg;

    localparam int CH_W   = 64;
    localparam int NUM_CH = 4;
    localparam int BEAT_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        CAPTURE
    } state_e;

    // Channel k carries bits [64k+63:64k] of the memory beat
    function automatic logic [CH_W-1:0] ch_slice(input logic [BEAT_W-1:0] beat, input int k);
        return beat[k*CH_W +: CH_W];
    endfunction

endpackage

// File: rtl/mac_beat_reg.sv
// mac_beat_reg: registers one 256-bit return beat onto the four MAC DMA channels with a one-cycle en strobe; channels hold when idle
module mac_beat_reg
    import mac_feeder_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic [BEAT_W-1:0]             data_i,
    output logic [NUM_CH-1:0][CH_W-1:0]   ch_o,
    output logic                          en_o
);

    logic [NUM_CH-1:0][CH_W-1:0] ch_q;
    logic                        en_q;

    // Capture a valid beat into the channels; en follows valid by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= valid_i;
            if (valid_i)
                for (int k = 0; k < NUM_CH; k++)
                    ch_q[k] <= ch_slice(data_i, k);
        end
    end

    assign ch_o = ch_q;
    assign en_o = en_q;

endmodule

// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder: fetches operand beats from memory, streams them into MAC_array and captures one dot_product per job.
// Optional FEEDER_PERF_CNT_EN adds perf_stall_cycles (STREAM cycles with a request stalled by mem_rd_ready).
module mac_stream_feeder
    import mac_feeder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 8,
    parameter int ACC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_beats,
    input  logic [15:0]       bias_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result_data,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ready,
    input  logic              mem_rd_valid,
    input  logic [BEAT_W-1:0] mem_rd_data,
    output logic [CH_W-1:0]   DMA_channel_0,
    output logic [CH_W-1:0]   DMA_channel_1,
    output logic [CH_W-1:0]   DMA_channel_2,
    output logic [CH_W-1:0]   DMA_channel_3,
    output logic              en,
    output logic              clr,
    output logic [15:0]       bias,
    output logic              read_en,
    input  logic [15:0]       dot_product
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int LAT_W = $clog2(ACC_LAT + 1);

    state_e               state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [15:0]          bias_q;
    logic [LEN_W:0]       issued_q;
    logic [LEN_W:0]       received_q;
    logic [LAT_W-1:0]     lat_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 clr_q;
    logic                 req_q;
    logic                 read_en_q;
    logic [15:0]          result_q;
    logic [NUM_CH-1:0][CH_W-1:0] ch;

    logic                 hs_d;
    logic                 beat_d;
    logic [LEN_W:0]       len_d;

    assign hs_d   = req_q && mem_rd_ready;
    assign beat_d = mem_rd_valid && (state_q == STREAM || state_q == DRAIN);
    assign len_d  = {1'b0, len_q};

    // Job sequencer: latch job, clear MAC, issue reads, wait for returns plus MAC latency, capture result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            bias_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            req_q      <= 1'b0;
            read_en_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            if (beat_d)
                received_q <= received_q + 1'b1;
            case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        addr_q     <= base_addr;
                        len_q      <= num_beats;
                        bias_q     <= bias_in;
                        issued_q   <= '0;
                        received_q <= '0;
                        lat_q      <= '0;
                        clr_q      <= 1'b1;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    req_q   <= len_q != '0;
                    state_q <= len_q == '0 ? DRAIN : STREAM;
                end
                STREAM: begin
                    if (hs_d) begin
                        addr_q   <= addr_q + 1'b1;
                        issued_q <= issued_q + 1'b1;
                        req_q    <= (issued_q + 1'b1) < len_d;
                    end
                    if (issued_q == len_d)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (received_q == len_d) begin
                        read_en_q <= 1'b1;
                        lat_q     <= lat_q + 1'b1;
                        if (lat_q == LAT_W'(ACC_LAT - 1))
                            state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result_q  <= dot_product;
                    done_q    <= 1'b1;
                    read_en_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mac_beat_reg u_beat_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (beat_d),
        .data_i  (mem_rd_data),
        .ch_o    (ch),
        .en_o    (en)
    );

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating count of stalled request cycles, restarted by each accepted job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else if (state_q == IDLE && start)
            perf_q <= '0;
        else if (state_q == STREAM && req_q && !mem_rd_ready && !(&perf_q))
            perf_q <= perf_q + 1'b1;
    end

    assign perf_stall_cycles = perf_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign result_data   = result_q;
    assign mem_rd_req    = req_q;
    assign mem_rd_addr   = addr_q;
    assign clr           = clr_q;
    assign bias          = bias_q;
    assign read_en       = read_en_q;
    assign DMA_channel_0 = ch[0];
    assign DMA_channel_1 = ch[1];
    assign DMA_channel_2 = ch[2];
    assign DMA_channel_3 = ch[3];

endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb_mac_stream_feeder: randomized jobs against a job-level reference model and a behavioural MAC_array stub
module tb_mac_stream_feeder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [7:0]   num_beats = '0;
    logic [15:0]  bias_in = '0;
    logic         busy, done, mem_rd_req, en, clr, read_en;
    logic [15:0]  result_data, bias, dot_product;
    logic [15:0]  mem_rd_addr;
    logic         mem_rd_ready = 1'b0;
    logic         mem_rd_valid = 1'b0;
    logic [255:0] mem_rd_data = '0;
    logic [63:0]  DMA_channel_0, DMA_channel_1, DMA_channel_2, DMA_channel_3;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0]  perf_stall_cycles;
`endif

    int           n_cmp = 0;
    int           n_err = 0;
    bit           fixed = 1'b0;
    logic [31:0]  seed = 32'h1234_5678;

    always #5 clk = ~clk;

    mac_stream_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_beats     (num_beats),
        .bias_in       (bias_in),
        .busy          (busy),
        .done          (done),
        .result_data   (result_data),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_ready  (mem_rd_ready),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .DMA_channel_0 (DMA_channel_0),
        .DMA_channel_1 (DMA_channel_1),
        .DMA_channel_2 (DMA_channel_2),
        .DMA_channel_3 (DMA_channel_3),
        .en            (en),
        .clr           (clr),
        .bias          (bias),
        .read_en       (read_en),
        .dot_product   (dot_product)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // MAC_array stand-in: clear loads bias, en accumulates four lane samples, output lags one extra register
    logic [15:0] acc_q = '0;
    logic [15:0] dp_q = '0;
    always @(posedge clk) begin
        if (clr)
            acc_q <= bias;
        else if (en)
            acc_q <= acc_q + DMA_channel_0[15:0] + DMA_channel_1[31:16] + DMA_channel_2[15:0] + DMA_channel_3[63:48];
        dp_q <= acc_q;
    end
    assign dot_product = dp_q;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_word(input logic [15:0] a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++)
            w[i*32 +: 32] = (32'(a) * 32'h9E37_79B9) ^ (seed + 32'(i) * 32'h0100_0193);
        return fixed ? {32{8'h55}} : w;
    endfunction

    // Contribution of one memory word to the MAC result, taken straight from the word's bit lanes
    function automatic logic [15:0] lane_sum(input logic [255:0] w);
        return w[15:0] + w[95:80] + w[143:128] + w[255:240];
    endfunction

    task automatic run_job(input logic [15:0] b, input logic [7:0] n, input logic [15:0] bi,
                           input int rmode, input bit poke, input int abort_at);
        logic [15:0]  ea, er;
        logic [255:0] q[$];
        logic [255:0] w, pd, lastd;
        logic         pv, pre;
        int           hs, ens, clrs, stalls, cyc;
        bit           fin;
        ea = b; er = bi; pv = 1'b0; pre = 1'b0; pd = '0; lastd = '0;
        hs = 0; ens = 0; clrs = 0; stalls = 0; cyc = 0; fin = 1'b0;
        base_addr = b; num_beats = n; bias_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_set", busy, 1'b1);
        chk("bias_drv", bias, bi);
        while (!fin && cyc < 4000) begin
            chk("en_lat", en, pv);
            if (pv)
                lastd = pd;
            if (pv || ens > 0)
                chk("dma", {DMA_channel_3, DMA_channel_2, DMA_channel_1, DMA_channel_0}, lastd);
            if (en)
                ens++;
            if (clr)
                clrs++;
            if (abort_at >= 0 && ens == abort_at)
                return;
            if (done) begin
                fin = 1'b1;
                chk("busy_at_done", busy, 1'b1);
                chk("read_en_pre", pre, 1'b1);
                chk("result", result_data, er);
                chk("handshakes", hs, n);
                chk("en_pulses", ens, n);
                chk("clr_pulses", clrs, 1);
`ifdef FEEDER_PERF_CNT_EN
                chk("perf_stall", perf_stall_cycles, stalls);
`endif
            end else begin
                pre = read_en;
                start = poke && cyc == 2;
                if (start) begin
                    base_addr = 16'h1234; num_beats = 8'd9; bias_in = ~bi;
                end
                pv = 1'b0;
                mem_rd_valid = 1'b0;
                mem_rd_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    pd = q.pop_front();
                    mem_rd_valid = 1'b1;
                    mem_rd_data = pd;
                    pv = 1'b1;
                end
                mem_rd_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                if (mem_rd_req) begin
                    chk("addr", mem_rd_addr, ea);
                    if (mem_rd_ready) begin
                        w = mem_word(ea);
                        q.push_back(w);
                        er = er + lane_sum(w);
                        ea = ea + 16'd1;
                        hs++;
                    end else
                        stalls++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin)
            chk("done_timeout", 1'b0, 1'b1);
        start = 1'b0;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("busy_drop", busy, 1'b0);
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result_data, 16'h0);
        chk("rst_req", mem_rd_req, 1'b0);
        chk("rst_addr", mem_rd_addr, 16'h0);
        chk("rst_en", en, 1'b0);
        chk("rst_clr", clr, 1'b0);
        chk("rst_bias", bias, 16'h0);
        chk("rst_read_en", read_en, 1'b0);
        chk("rst_dma", {DMA_channel_3, DMA_channel_2, DMA_channel_1, DMA_channel_0}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fixed = 1'b1;
        run_job(16'h0010, 8'd4, 16'h0010, 0, 1'b0, -1);
        fixed = 1'b0;
        seed = $urandom;
        run_job(16'h0100, 8'd3, 16'($urandom), 1, 1'b0, -1);
        run_job(16'hFFFE, 8'd4, 16'($urandom), 2, 1'b0, -1);
        run_job(16'h0040, 8'd0, 16'h0ABC, 2, 1'b1, -1);
        for (int j = 0; j < 6; j++)
            run_job(16'($urandom), 8'($urandom_range(0, 12)), 16'($urandom), 2, 1'b0, -1);
        run_job(16'($urandom), 8'd255, 16'($urandom), 2, 1'b0, -1);
        run_job(16'h0200, 8'd5, 16'h0777, 0, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_req", mem_rd_req, 1'b0);
        chk("mid_rst_en", en, 1'b0);
        chk("mid_rst_bias", bias, 16'h0);
        chk("mid_rst_result", result_data, 16'h0);
        chk("mid_rst_read_en", read_en, 1'b0);
        chk("mid_rst_dma", {DMA_channel_3, DMA_channel_2, DMA_channel_1, DMA_channel_0}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = {8{32'hDEAD_BEEF}};
            @(negedge clk);
            chk("late_en", en, 1'b0);
            chk("late_busy", busy, 1'b0);
            chk("late_req", mem_rd_req, 1'b0);
        end
        mem_rd_valid = 1'b0;
        @(negedge clk);
        run_job(16'h0300, 8'd5, 16'h0101, 2, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_stream_feeder.md
Name: mac_stream_feeder

Overview:
Transmit-side companion of MAC_array. Fetches 256-bit operand beats from an on-chip read port and drives the four 64-bit DMA channels of MAC_array. Sequences the array's en/clr/read_en/bias controls and captures the returned 16-bit dot_product as one result per job. Sits between the DMA/memory fabric and the MAC_array instance.

Parameters:
ADDR_W, 16, memory word-address width (one word = 256 bits)
LEN_W, 8, width of the beat-count field
ACC_LAT, 2, cycles from the last en beat until dot_product is valid at MAC_array output

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job request; sampled only in IDLE
base_addr  in  ADDR_W  first word address of the job
num_beats  in  LEN_W  number of 256-bit beats in the job; 0 allowed
bias_in  in  16  bias for this job
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when result_data is updated
result_data  out  16  captured dot_product
mem_rd_req  out  1  read request
mem_rd_addr  out  ADDR_W  read word address
mem_rd_ready  in  1  request accepted when mem_rd_req && mem_rd_ready
mem_rd_valid  in  1  return beat valid; in order; never back-pressured
mem_rd_data  in  256  return beat
DMA_channel_0..3  out  64 each  to MAC_array; channel k = mem_rd_data[64k+63:64k]
en  out  1  MAC accumulate enable, one cycle per beat
clr  out  1  MAC accumulator clear
bias  out  16  bias to MAC_array, held for the job
read_en  out  1  MAC output read enable
dot_product  in  16  MAC_array result

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CAPTURE.
- IDLE: on start, latch base_addr, num_beats and bias_in. Drive bias on the next cycle. Go to CLEAR and set busy. Start in any other state is ignored.
- CLEAR: clr=1 for exactly one cycle. Next state is STREAM, or DRAIN if num_beats==0.
- STREAM, request side:
  - mem_rd_req=1 while issued<num_beats.
  - On each handshake, mem_rd_addr increments by 1 and issued increments.
  - Address wraps modulo 2^ADDR_W.
  - mem_rd_addr is stable while req is high and ready is low.
- Return side (active in STREAM and DRAIN):
  - Each mem_rd_valid beat is registered onto DMA_channel_0..3 with en=1 in the following cycle, so latency is 1 cycle.
  - received increments per beat.
  - en=0 on cycles with no valid beat; channels hold their last value.
  - Returns arriving in the same cycle as a request handshake are both processed.
- STREAM -> DRAIN when issued==num_beats.
- DRAIN: wait until received==num_beats, then count ACC_LAT cycles with read_en=1, then go to CAPTURE.
- CAPTURE: result_data<=dot_product; done=1 for one cycle; read_en=1; busy drops the cycle after; go to IDLE.
- num_beats==0: no memory requests; result is the MAC output after clr (bias path only).
- Reset mid-job: immediate return to IDLE; outstanding returns after reset deassertion are discarded (IDLE ignores mem_rd_valid).
- Counter widths: LEN_W+1 bits, so num_beats=2^LEN_W-1 is safe.

Optional Feature:
Macro FEEDER_PERF_CNT_EN.
- Defined: adds output perf_stall_cycles[31:0].
  - Counts cycles in STREAM with mem_rd_req=1 && mem_rd_ready=0.
  - Cleared on accepted start; saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package mac_feeder_pkg holds:
  - FSM state enum (IDLE..CAPTURE)
  - CH_W=64, NUM_CH=4, BEAT_W=256
  - the channel slice mapping
- One natural sub-module, mac_beat_reg: registers the 256-bit beat into the four channels plus en, with hold-on-idle.
- Request and control logic stay in the top module.

Test Plan:
- Reset with rst_n=0, then release → all outputs 0, busy=0. After start with base_addr=0x0010, num_beats=4, bias_in=0x0010: clr pulses once, then addresses 0x10..0x13 are issued.
- Memory returns 0x5555…5555 on each beat with ready always high → four en pulses, each one cycle after its valid. After ACC_LAT, done=1 and result_data equals the MAC model value; busy drops the next cycle.
- Toggle mem_rd_ready 1-0-1-0 with num_beats=3 → address held during stalls, exactly 3 handshakes. With FEEDER_PERF_CNT_EN, perf_stall_cycles equals the stalled-cycle count.
- base_addr=0xFFFE, num_beats=4 → addresses FFFE, FFFF, 0000, 0001.
- num_beats=0 → no mem_rd_req; clr, then done after ACC_LAT cycles with result_data = bias-only MAC value. A start pulse during busy is ignored.
- Assert rst_n=0 during STREAM after 2 of 5 beats → outputs cleared, FSM in IDLE; late mem_rd_valid beats produce no en.
